// File: rtl/config_pkg.sv
// Shared definitions for the ALU packet controller.
// - state_e : controller FSM states
// - OPC_*   : recognised packet opcodes
// - is_opcode() : true for any recognised opcode byte
package config_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RSVD,
      ST_LEN_L,
      ST_LEN_M,
      ST_ECHO,
      ST_OPERAND,
      ST_ALU_REQ,
      ST_ALU_WAIT,
      ST_RESULT,
      ST_DRAIN
   } state_e;

   localparam logic [7:0] OPC_ECHO = 8'hEC;
   localparam logic [7:0] OPC_ADD  = 8'hAD;
   localparam logic [7:0] OPC_MUL  = 8'h88;
   localparam logic [7:0] OPC_DIV  = 8'h8F;

   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OPC_ECHO) || (b == OPC_ADD) || (b == OPC_MUL) || (b == OPC_DIV);
   endfunction

endpackage

// File: rtl/shift_in_le.sv
// Byte-to-word little-endian assembler.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clr_i       : restart assembly of a new word
//   en_i        : accept data_i this cycle
//   data_i      : incoming byte (first byte lands in bits 7:0)
//   word_o      : registered assembled word
//   word_next_o : word including the byte accepted this cycle
//   last_o      : this cycle's byte completes a word
module shift_in_le #(
   parameter int unsigned OP_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_i,
   input  logic            en_i,
   input  logic [7:0]      data_i,
   output logic [OP_W-1:0] word_o,
   output logic [OP_W-1:0] word_next_o,
   output logic            last_o
);
   import config_pkg::*;

   localparam int unsigned NB = OP_W / 8;

   logic [OP_W-1:0] word_q;
   logic [OP_W-1:0] byte_ext;
   logic [3:0]      cnt_q;

   // Bytes enter at the top and shift down, so after NB bytes the first
   // byte sits in bits 7:0.
   always_comb begin
      byte_ext    = OP_W'(data_i);
      word_next_o = (word_q >> 8) | (byte_ext << (OP_W - 8));
      last_o      = en_i && (cnt_q == 4'(NB - 1));
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (en_i) begin
         word_q <= word_next_o;
         cnt_q  <= last_o ? '0 : cnt_q + 4'd1;
      end
   end

   assign word_o = word_q;

endmodule

// File: rtl/alu_packet_ctrl.sv
// Packet controller: parses a byte stream of opcode/reserved/LEN packets,
// echoes ECHO payloads, and folds ALU packet operands through an external
// ALU, returning the RES_W-bit result LSB first.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   data_i/valid_i/ready_o            : upstream byte stream
//   data_o/valid_o/ready_i            : downstream byte stream
//   alu_op_o/alu_a_o/alu_b_o          : ALU request payload
//   alu_req_valid_o/alu_req_ready_i   : ALU request handshake
//   alu_rsp_valid_i/alu_rsp_data_i    : ALU response
//   err_o                             : one-cycle pulse on malformed packet
module alu_packet_ctrl #(
   parameter int unsigned OP_W    = 32,
   parameter int unsigned RES_W   = 64,
   parameter int unsigned MAX_OPS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [7:0]       data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [7:0]       alu_op_o,
   output logic [RES_W-1:0] alu_a_o,
   output logic [OP_W-1:0]  alu_b_o,
   output logic             alu_req_valid_o,
   input  logic             alu_req_ready_i,
   input  logic             alu_rsp_valid_i,
   input  logic [RES_W-1:0] alu_rsp_data_i,
   output logic             err_o
);
   import config_pkg::*;

   localparam int unsigned OPB = OP_W / 8;
   localparam int unsigned RB  = RES_W / 8;
   localparam int unsigned RIW = (RB > 1) ? $clog2(RB) : 1;

   state_e           state_q;
   logic [7:0]       opcode_q;
   logic [7:0]       len_lo_q;
   logic [15:0]      cnt_q;
   logic [RES_W-1:0] acc_q;
   logic             first_q;
   logic [RIW-1:0]   res_idx_q;
   logic             err_q;

   logic             fire_in;
   logic [15:0]      len_full;
   logic [15:0]      payload;
   logic             len_ok;
   logic [RES_W-1:0] res_sh;
   logic             sh_en;
   logic             sh_clr;
   logic             sh_last;
   logic [OP_W-1:0]  sh_word;
   logic [OP_W-1:0]  sh_word_next;

   shift_in_le #(.OP_W(OP_W)) u_shift (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (sh_clr),
      .en_i        (sh_en),
      .data_i      (data_i),
      .word_o      (sh_word),
      .word_next_o (sh_word_next),
      .last_o      (sh_last)
   );

   always_comb begin
      fire_in  = valid_i && ready_o;
      len_full = {data_i, len_lo_q};
      payload  = len_full - 16'd4;
      len_ok   = ((32'(payload) % OPB) == 0) &&
                 (32'(payload) >= 2 * OPB) &&
                 (32'(payload) <= MAX_OPS * OPB);
      sh_en    = (state_q == ST_OPERAND) && fire_in;
      sh_clr   = (state_q == ST_LEN_M);
      res_sh   = acc_q >> {res_idx_q, 3'b000};

      ready_o = 1'b0;
      valid_o = 1'b0;
      data_o  = '0;
      unique case (state_q)
         ST_IDLE, ST_RSVD, ST_LEN_L, ST_LEN_M, ST_OPERAND, ST_DRAIN: ready_o = 1'b1;
         ST_ECHO: begin
            ready_o = ready_i;
            valid_o = valid_i;
            data_o  = data_i;
         end
         ST_RESULT: begin
            valid_o = 1'b1;
            data_o  = res_sh[7:0];
         end
         default: ;
      endcase
      if (rst) ready_o = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         opcode_q  <= '0;
         len_lo_q  <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         first_q   <= 1'b0;
         res_idx_q <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: if (fire_in && is_opcode(data_i)) begin
               opcode_q <= data_i;
               state_q  <= ST_RSVD;
            end
            ST_RSVD: if (fire_in) state_q <= ST_LEN_L;
            ST_LEN_L: if (fire_in) begin
               len_lo_q <= data_i;
               state_q  <= ST_LEN_M;
            end
            ST_LEN_M: if (fire_in) begin
               cnt_q <= payload;
               if (len_full <= 16'd4) begin
                  state_q <= ST_IDLE;
               end else if (opcode_q == OPC_ECHO) begin
                  state_q <= ST_ECHO;
               end else if (len_ok) begin
                  first_q <= 1'b1;
                  state_q <= ST_OPERAND;
               end else begin
                  err_q   <= 1'b1;
                  state_q <= ST_DRAIN;
               end
            end
            ST_ECHO, ST_DRAIN: if (fire_in) begin
               cnt_q <= cnt_q - 16'd1;
               if (cnt_q == 16'd1) state_q <= ST_IDLE;
            end
            ST_OPERAND: if (fire_in) begin
               cnt_q <= cnt_q - 16'd1;
               if (sh_last) begin
                  // First operand seeds the accumulator directly; later
                  // operands go through the ALU with the registered word.
                  if (first_q) begin
                     acc_q   <= RES_W'(sh_word_next);
                     first_q <= 1'b0;
                  end else begin
                     state_q <= ST_ALU_REQ;
                  end
               end
            end
            ST_ALU_REQ: if (alu_req_ready_i) state_q <= ST_ALU_WAIT;
            ST_ALU_WAIT: if (alu_rsp_valid_i) begin
               acc_q <= alu_rsp_data_i;
               if (cnt_q == 16'd0) begin
                  res_idx_q <= '0;
                  state_q   <= ST_RESULT;
               end else begin
                  state_q <= ST_OPERAND;
               end
            end
            ST_RESULT: if (ready_i) begin
               if (res_idx_q == RIW'(RB - 1)) state_q <= ST_IDLE;
               else res_idx_q <= res_idx_q + 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign alu_op_o        = opcode_q;
   assign alu_a_o         = acc_q;
   assign alu_b_o         = sh_word;
   assign alu_req_valid_o = (state_q == ST_ALU_REQ);
   assign err_o           = err_q;

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Self-checking bench for alu_packet_ctrl with a behavioural ALU model.
module tb_alu_packet_ctrl;
   localparam int unsigned OP_W    = 32;
   localparam int unsigned RES_W   = 64;
   localparam int unsigned MAX_OPS = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       data_i;
   logic             valid_i;
   logic             ready_o;
   logic [7:0]       data_o;
   logic             valid_o;
   logic             ready_i;
   logic [7:0]       alu_op_o;
   logic [RES_W-1:0] alu_a_o;
   logic [OP_W-1:0]  alu_b_o;
   logic             alu_req_valid_o;
   logic             alu_req_ready_i;
   logic             alu_rsp_valid_i;
   logic [RES_W-1:0] alu_rsp_data_i;
   logic             err_o;

   always #5 clk = ~clk;

   alu_packet_ctrl #(.OP_W(OP_W), .RES_W(RES_W), .MAX_OPS(MAX_OPS)) dut (
      .clk             (clk),
      .rst             (rst),
      .data_i          (data_i),
      .valid_i         (valid_i),
      .ready_o         (ready_o),
      .data_o          (data_o),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .alu_op_o        (alu_op_o),
      .alu_a_o         (alu_a_o),
      .alu_b_o         (alu_b_o),
      .alu_req_valid_o (alu_req_valid_o),
      .alu_req_ready_i (alu_req_ready_i),
      .alu_rsp_valid_i (alu_rsp_valid_i),
      .alu_rsp_data_i  (alu_rsp_data_i),
      .err_o           (err_o)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0]  op;
      logic [63:0] a;
      logic [31:0] b;
   } req_t;

   typedef struct {
      logic [159:0] pkt;
      int           n;
      logic [63:0]  exp;
      int           en;
      int           errs;
      int           nreq;
      int           rmode;
   } vec_t;

   logic [7:0] out_q[$];
   req_t       req_q[$];
   int         err_cnt = 0;
   int         rdy_mode = 0;
   vec_t       vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = stalled
   initial begin
      ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ~ready_i;
            default: ready_i = 1'b0;
         endcase
      end
   end

   // Output / error monitor, sampled mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (valid_o && ready_i) out_q.push_back(data_o);
            if (err_o) err_cnt++;
         end
      end
   end

   // Behavioural ALU: one response, one cycle after acceptance
   initial begin
      alu_rsp_valid_i = 1'b0;
      alu_rsp_data_i  = '0;
      forever begin
         @(negedge clk);
         if (!rst && alu_req_valid_o && alu_req_ready_i) begin
            req_t r;
            r.op = alu_op_o;
            r.a  = alu_a_o;
            r.b  = alu_b_o;
            req_q.push_back(r);
            @(posedge clk);
            #1;
            alu_rsp_valid_i = 1'b1;
            case (r.op)
               8'hAD:   alu_rsp_data_i = r.a + 64'(r.b);
               8'h88:   alu_rsp_data_i = r.a * 64'(r.b);
               default: alu_rsp_data_i = (r.b == 0) ? 64'd0 : r.a / 64'(r.b);
            endcase
            @(posedge clk);
            #1;
            alu_rsp_valid_i = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok      = 1'b0;
      data_i  = b;
      valid_i = 1'b1;
      for (int t = 0; t < 60 && !ok; t++) begin
         @(negedge clk);
         if (ready_o) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte %0h not accepted within 60 cycles", b);
      end
   endtask

   task automatic send_pkt(input logic [159:0] pkt, input int n);
      for (int k = 0; k < n; k++) send_byte(pkt[k*8 +: 8]);
      valid_i = 1'b0;
   endtask

   task automatic wait_out(input int n);
      for (int t = 0; t < 80 && out_q.size() < n; t++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic wait_sig_neg(input string name, input int which);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         seen = (which == 0) ? alu_req_valid_o : valid_o;
      end
      check(name, 64'(seen), 64'd1);
   endtask

   initial begin
      // {packet bytes (byte 0 in bits 7:0), count, expected output value, bytes, err pulses, ALU reqs, ready mode}
      vecs[0] = '{160'h42_41_00_06_00_EC, 6, 64'h4241, 2, 0, 0, 1};
      vecs[1] = '{160'h00000003_00000002_00000001_001000AD, 16, 64'd6, 8, 0, 2, 0};
      vecs[2] = '{160'h00000005_00000003_000C0088, 12, 64'd15, 8, 0, 1, 0};
      vecs[3] = '{160'h00000007_00000064_000C008F, 12, 64'd14, 8, 0, 1, 0};
      vecs[4] = '{160'h55_00_05_00_EC_00_04_00_AD, 9, 64'h55, 1, 0, 0, 0};
      vecs[5] = '{160'h77_00_05_00_EC_A3_A2_A1_00_07_00_AD, 12, 64'h77, 1, 1, 0, 0};
      vecs[6] = '{160'h33_00_05_00_EC_00_00_00_09_00_08_00_AD, 13, 64'h33, 1, 1, 0, 0};
      vecs[7] = '{160'h66_00_05_00_EC_12_00, 7, 64'h66, 1, 0, 0, 0};
      vecs[8] = '{160'h00000100_00010000_00010000_00100088, 16, 64'h0000_0100_0000_0000, 8, 0, 2, 0};

      rst             = 1'b1;
      valid_i         = 1'b0;
      data_i          = '0;
      alu_req_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready_o", 64'(ready_o), 64'd0);
      check("rst_valid_o", 64'(valid_o), 64'd0);
      check("rst_alu_req_valid", 64'(alu_req_valid_o), 64'd0);
      check("rst_err_o", 64'(err_o), 64'd0);
      check("rst_data_o", 64'(data_o), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready_o", 64'(ready_o), 64'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         out_q.delete();
         req_q.delete();
         err_cnt  = 0;
         rdy_mode = vecs[i].rmode;
         send_pkt(vecs[i].pkt, vecs[i].n);
         wait_out(vecs[i].en);
         rdy_mode = 0;
         check($sformatf("v%0d_out_count", i), 64'(out_q.size()), 64'(vecs[i].en));
         for (int k = 0; k < vecs[i].en; k++)
            check($sformatf("v%0d_byte%0d", i, k),
                  (k < out_q.size()) ? 64'(out_q[k]) : 64'hxx,
                  64'(vecs[i].exp[k*8 +: 8]));
         check($sformatf("v%0d_err_pulses", i), 64'(err_cnt), 64'(vecs[i].errs));
         check($sformatf("v%0d_alu_reqs", i), 64'(req_q.size()), 64'(vecs[i].nreq));
         if (i == 1 && req_q.size() == 2) begin
            check("add_req0_a", req_q[0].a, 64'd1);
            check("add_req0_b", 64'(req_q[0].b), 64'd2);
            check("add_req1_a", req_q[1].a, 64'd3);
            check("add_req1_b", 64'(req_q[1].b), 64'd3);
            check("add_req_op", 64'(req_q[1].op), 64'hAD);
         end
      end

      // Reset while a MUL request is pending and never accepted
      out_q.delete();
      req_q.delete();
      alu_req_ready_i = 1'b0;
      send_pkt(160'h00000003_00000002_000C0088, 12);
      wait_sig_neg("mulrst_req_pending", 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("mulrst_ready_in_rst", 64'(ready_o), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mulrst_req_dropped", 64'(alu_req_valid_o), 64'd0);
      check("mulrst_valid_o", 64'(valid_o), 64'd0);
      @(posedge clk);
      #1;
      alu_req_ready_i = 1'b1;
      send_pkt(160'h5A_00_05_00_EC, 5);
      wait_out(1);
      check("mulrst_out_count", 64'(out_q.size()), 64'd1);
      check("mulrst_echo_byte", (out_q.size() > 0) ? 64'(out_q[0]) : 64'hxx, 64'h5A);
      check("mulrst_no_alu_req", 64'(req_q.size()), 64'd0);

      // Delayed ALU acceptance and downstream stall in RESULT
      out_q.delete();
      req_q.delete();
      alu_req_ready_i = 1'b0;
      rdy_mode        = 2;
      send_pkt(160'h11111111_12345678_000C00AD, 12);
      wait_sig_neg("hold_req_seen", 0);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("hold_req_valid_c%0d", c), 64'(alu_req_valid_o), 64'd1);
         check($sformatf("hold_a_c%0d", c), alu_a_o, 64'h12345678);
         check($sformatf("hold_b_c%0d", c), 64'(alu_b_o), 64'h11111111);
         check($sformatf("hold_ready_o_c%0d", c), 64'(ready_o), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      alu_req_ready_i = 1'b1;
      wait_sig_neg("hold_result_seen", 1);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("hold_data_c%0d", c), 64'(data_o), 64'h89);
         check($sformatf("hold_valid_c%0d", c), 64'(valid_o), 64'd1);
         if (c < 2) @(negedge clk);
      end
      rdy_mode = 0;
      wait_out(8);
      check("hold_out_count", 64'(out_q.size()), 64'd8);
      for (int k = 0; k < 8; k++)
         check($sformatf("hold_byte%0d", k),
               (k < out_q.size()) ? 64'(out_q[k]) : 64'hxx,
               64'h00000000_23456789 >> (k * 8) & 64'hFF);
      check("hold_alu_reqs", 64'(req_q.size()), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
